// File: rtl/clock_period_monitor.sv
// rtl/clock_period_monitor.sv - slow-clock period/high-time monitor; CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN adds duty_ok
module clock_period_monitor #(
  parameter int EXPECTED_PERIOD_CYCLES = 100000000,
  parameter int TOLERANCE_CYCLES       = 2,
  localparam int TIMEOUT_CYCLES        = 2 * EXPECTED_PERIOD_CYCLES,
  localparam int W                     = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         sys_clk,
  input  logic         rstn,
  input  logic         clk_in,
  input  logic         enable,
  output logic [W-1:0] period_cycles,
  output logic [W-1:0] high_cycles,
  output logic         meas_valid,
  output logic         freq_ok,
  output logic         clk_lost
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
  ,
  output logic         duty_ok
`endif
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOST} state_t;

  localparam logic [W-1:0]        TIMEOUT_W  = W'(TIMEOUT_CYCLES);
  localparam logic [W:0]          TIMEOUT_X  = (W+1)'(TIMEOUT_CYCLES);
  localparam logic signed [W:0]   EXPECTED_S = (W+1)'(EXPECTED_PERIOD_CYCLES);
  localparam logic signed [W:0]   TOL_S      = (W+1)'(TOLERANCE_CYCLES);

  state_t       state_q, state_d;
  logic         sync1_q, sync2_q, sync3_q;
  logic         rise_det, fall_det;
  logic [W-1:0] cnt;
  logic [W-1:0] hi_tmp, hi_tmp_d;
  logic         fall_seen, fall_seen_d;
  logic [W-1:0] period_d, high_d;
  logic         meas_valid_d, freq_ok_d, clk_lost_d;

  logic [W:0]        cnt_plus1;
  logic [W-1:0]      meas_period, meas_high;
  logic signed [W:0] per_err, per_mag;
  logic              in_tol;

`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
  localparam logic signed [W+1:0] DUTY_TOL_S = (W+2)'(2 * TOLERANCE_CYCLES);
  logic signed [W+1:0] duty_err, duty_mag;
  logic                duty_in_tol, duty_ok_d;
`endif

  // Two-flop synchronizer on clk_in followed by a registered edge detector
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      rise_det <= 1'b0;
      fall_det <= 1'b0;
    end else begin
      sync1_q  <= clk_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      rise_det <= sync2_q & ~sync3_q;
      fall_det <= ~sync2_q & sync3_q;
    end
  end

  // Cycle counter since the last detected rise, saturating at the timeout
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (rise_det) begin
      cnt <= '0;
    end else if (cnt != TIMEOUT_W) begin
      cnt <= cnt + W'(1);
    end
  end

  // Candidate measurement values and tolerance checks for the current cycle
  always_comb begin
    cnt_plus1   = {1'b0, cnt} + (W+1)'(1);
    meas_period = cnt_plus1[W-1:0];
    meas_high   = fall_seen ? hi_tmp : '0;
    per_err     = $signed(cnt_plus1) - EXPECTED_S;
    per_mag     = per_err[W] ? -per_err : per_err;
    in_tol      = (per_mag <= TOL_S);
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
    duty_err    = $signed({1'b0, meas_high, 1'b0}) - $signed({2'b00, meas_period});
    duty_mag    = duty_err[W+1] ? -duty_err : duty_err;
    duty_in_tol = (duty_mag <= DUTY_TOL_S);
`endif
  end

  // Next-state and next-output logic; enable low overrides every state
  always_comb begin
    state_d      = state_q;
    hi_tmp_d     = hi_tmp;
    fall_seen_d  = fall_seen;
    period_d     = period_cycles;
    high_d       = high_cycles;
    meas_valid_d = 1'b0;
    freq_ok_d    = freq_ok;
    clk_lost_d   = clk_lost;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
    duty_ok_d    = duty_ok;
`endif
    if (!enable) begin
      state_d    = IDLE;
      freq_ok_d  = 1'b0;
      clk_lost_d = 1'b0;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
      duty_ok_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = ACQUIRE;
        ACQUIRE: begin
          if (rise_det) begin
            state_d     = MEASURE;
            hi_tmp_d    = '0;
            fall_seen_d = 1'b0;
          end
        end
        MEASURE: begin
          if (fall_det) begin
            hi_tmp_d    = meas_period;
            fall_seen_d = 1'b1;
          end
          // An edge landing on the timeout cycle is a normal measurement
          if (rise_det) begin
            period_d     = meas_period;
            high_d       = meas_high;
            meas_valid_d = 1'b1;
            freq_ok_d    = in_tol & fall_seen;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
            duty_ok_d    = duty_in_tol;
`endif
            hi_tmp_d     = '0;
            fall_seen_d  = 1'b0;
          end else if (cnt_plus1 == TIMEOUT_X) begin
            state_d    = LOST;
            clk_lost_d = 1'b1;
            freq_ok_d  = 1'b0;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
            duty_ok_d  = 1'b0;
`endif
          end
        end
        LOST: begin
          if (rise_det) begin
            state_d     = MEASURE;
            clk_lost_d  = 1'b0;
            hi_tmp_d    = '0;
            fall_seen_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      hi_tmp        <= '0;
      fall_seen     <= 1'b0;
      period_cycles <= '0;
      high_cycles   <= '0;
      meas_valid    <= 1'b0;
      freq_ok       <= 1'b0;
      clk_lost      <= 1'b0;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
      duty_ok       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hi_tmp        <= hi_tmp_d;
      fall_seen     <= fall_seen_d;
      period_cycles <= period_d;
      high_cycles   <= high_d;
      meas_valid    <= meas_valid_d;
      freq_ok       <= freq_ok_d;
      clk_lost      <= clk_lost_d;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
      duty_ok       <= duty_ok_d;
`endif
    end
  end

endmodule
